icache_ctrl: RTL and testbench

- Fetch-side controller between the IFU and the direct-mapped, one-word-per-line instruction cache.
- Accepts one fetch at a time and runs the cache lookup. On a miss it issues a single-word memory read, fills the cache line, then returns the word to the IFU.
- Addresses in a configurable uncached window bypass the cache entirely.
- Keeps hit, miss and bypass performance counters.

---
 rtl/icache_ctrl_if.sv | 43 ++++
 rtl/icache_ctrl.sv | 126 ++++++++++++
 tb/tb_icache_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Fetch-side bus bundle for the icache controller: IFU request/response, cache lookup/fill, memory read.
// The controller takes the slave view; the surrounding IFU, cache array and memory take the master view.
interface icache_ctrl_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [29:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        ic_req_valid;
  logic [29:0] ic_addr;
  logic        ic_is_hit;
  logic [31:0] ic_rdata;
  logic        ic_wen;
  logic [31:0] ic_wdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ic_is_hit, ic_rdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output ic_req_valid, ic_addr, ic_wen, ic_wdata,
    output mem_req_valid, mem_addr
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ic_is_hit, ic_rdata,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  ic_req_valid, ic_addr, ic_wen, ic_wdata,
    input  mem_req_valid, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Single-outstanding fetch controller for a direct-mapped, one-word-per-line instruction cache,
// with an uncached bypass window and hit/miss/bypass counters.
module icache_ctrl #(
  parameter logic [31:0] UC_BASE = 32'hA000_0000,
  parameter logic [31:0] UC_MASK = 32'hF000_0000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  icache_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] byp_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;

  state_t      state;
  logic [29:0] addr_q;
  logic        uc_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        req_ready_q;
  logic        ic_req_q;
  logic        mem_req_q;
  logic        wen_q;
  logic        resp_q;
  logic        uc_dec;

  assign uc_dec = (({bus.ifu_addr, 2'b00} & UC_MASK) == UC_BASE);

  // NOTE: all state here is sequential, so every assignment is non-blocking; blocking would let
  // later statements in the same edge see half-updated values and break sim/synth equivalence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      uc_q        <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      ic_req_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      wen_q       <= 1'b0;
      resp_q      <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      byp_cnt     <= '0;
    end else begin
      // Lookup strobe and fill enable only ever last one cycle.
      ic_req_q <= 1'b0;
      wen_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ifu_req_valid && req_ready_q) begin
            addr_q      <= bus.ifu_addr;
            uc_q        <= uc_dec;
            ic_req_q    <= !uc_dec;
            req_ready_q <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (uc_q) begin
            byp_cnt   <= byp_cnt + CNT_W'(1);
            mem_req_q <= 1'b1;
            state     <= MEM_REQ;
          end else if (bus.ic_is_hit) begin
            data_q  <= bus.ic_rdata;
            err_q   <= 1'b0;
            hit_cnt <= hit_cnt + CNT_W'(1);
            resp_q  <= 1'b1;
            state   <= RESP;
          end else begin
            miss_cnt  <= miss_cnt + CNT_W'(1);
            mem_req_q <= 1'b1;
            state     <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_q <= 1'b0;
            state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            data_q <= bus.mem_rdata;
            err_q  <= bus.mem_resp_err;
            // Errored or uncached data must never land in the cache.
            if (bus.mem_resp_err || uc_q) begin
              resp_q <= 1'b1;
              state  <= RESP;
            end else begin
              wen_q <= 1'b1;
              state <= FILL;
            end
          end
        end
        FILL: begin
          resp_q <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (bus.ifu_resp_ready) begin
            resp_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is held low while reset is asserted so every output reads zero during reset.
  assign bus.ifu_req_ready  = req_ready_q & ~reset;
  assign bus.ifu_resp_valid = resp_q;
  assign bus.ifu_rdata      = resp_q ? data_q : '0;
  assign bus.ifu_resp_err   = resp_q & err_q;
  assign bus.ic_req_valid   = ic_req_q;
  assign bus.ic_addr        = addr_q;
  assign bus.ic_wen         = wen_q;
  assign bus.ic_wdata       = wen_q ? data_q : '0;
  assign bus.mem_req_valid  = mem_req_q;
  assign bus.mem_addr       = mem_req_q ? {addr_q, 2'b00} : '0;
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a driver issues fetches and queues expected results from a
// behavioural cache model; monitors and a memory responder pop and compare as the DUT responds.
module tb_icache_ctrl;
  localparam int CNT_W = 4;

  typedef struct { logic [31:0] data; logic err; } resp_t;
  typedef struct { logic [29:0] addr; logic [31:0] data; } fill_t;

  logic clock;
  logic reset;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, byp_cnt;

  icache_ctrl_if bus ();

  icache_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .byp_cnt(byp_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int n_lookup = 0;
  int exp_hit = 0, exp_miss = 0, exp_byp = 0;

  resp_t       exp_resp[$];
  fill_t       exp_fill[$];
  logic [31:0] exp_mem[$];

  // Reference model: tag store of what the cache should hold.
  bit          ref_v[16];
  logic [29:0] ref_tag[16];
  // Cache array the DUT actually reads and fills.
  bit          env_v[16];
  logic [29:0] env_tag[16];
  logic [31:0] env_data[16];

  // Memory responder knobs for the fetch in flight.
  bit cfg_err, cfg_spur, cfg_late;
  int cfg_rdly, cfg_mdly;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic flag(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'h2000_0004) return 32'h0000_0013;
    return {wa, 2'b11} ^ 32'h5A00_C3C3;
  endfunction

  function automatic bit is_uc(input logic [29:0] wa);
    return ({wa, 2'b00} & 32'hF000_0000) == 32'hA000_0000;
  endfunction

  always_comb begin
    bus.ic_is_hit = env_v[bus.ic_addr[3:0]] && (env_tag[bus.ic_addr[3:0]] == bus.ic_addr);
    bus.ic_rdata  = env_data[bus.ic_addr[3:0]];
  end

  always @(posedge clock) begin
    if (bus.ic_wen) begin
      env_v[bus.ic_addr[3:0]]    <= 1'b1;
      env_tag[bus.ic_addr[3:0]]  <= bus.ic_addr;
      env_data[bus.ic_addr[3:0]] <= bus.ic_wdata;
    end
  end

  // Memory responder: checks each request, optionally stalls ready, injects a stray response in
  // the ready cycle, and returns data after a delay (or only after a reset in late mode).
  initial begin : mem_model
    logic [31:0] a;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_rdata = '0; bus.mem_resp_err = 1'b0;
    forever begin
      @(negedge clock); #2;
      if (bus.mem_req_valid && !reset) begin
        a = bus.mem_addr;
        if (exp_mem.size() == 0) flag("mem_unexpected", $sformatf("request to 0x%0h, none required", a));
        else check("mem_addr", a, exp_mem.pop_front());
        for (int k = 0; k < cfg_rdly; k++) begin
          @(negedge clock); #2;
          check("mem_req_hold", {bus.mem_req_valid, bus.mem_addr}, {1'b1, a});
        end
        bus.mem_req_ready = 1'b1;
        if (cfg_spur) begin
          bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_resp_err = 1'b1;
        end
        @(negedge clock); #2;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_rdata = '0; bus.mem_resp_err = 1'b0;
        if (cfg_late) begin
          for (int k = 0; k < 50 && !reset; k++) begin @(negedge clock); #2; end
          for (int k = 0; k < 50 && reset; k++) begin @(negedge clock); #2; end
          @(negedge clock); #2;
        end else begin
          for (int k = 0; k < cfg_mdly; k++) begin @(negedge clock); #2; end
        end
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = mem_word(a[31:2]); bus.mem_resp_err = cfg_err;
        @(negedge clock); #2;
        bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0; bus.mem_resp_err = 1'b0;
      end
    end
  end

  // Monitor: response scoreboard, hold-stability under backpressure, fill scoreboard, lookup count.
  initial begin : monitor
    resp_t r;
    fill_t f;
    logic stalled;
    logic [32:0] held;
    stalled = 1'b0;
    forever begin
      @(negedge clock); #2;
      if (bus.ifu_resp_valid) begin
        if (stalled) check("resp_stable", {bus.ifu_resp_err, bus.ifu_rdata}, held);
        if (bus.ifu_resp_ready) begin
          if (exp_resp.size() == 0) flag("resp_unexpected", $sformatf("data 0x%0h, no response required", bus.ifu_rdata));
          else begin
            r = exp_resp.pop_front();
            check("resp_data", bus.ifu_rdata, r.data);
            check("resp_err", bus.ifu_resp_err, r.err);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {bus.ifu_resp_err, bus.ifu_rdata};
        end
      end else stalled = 1'b0;
      if (bus.ic_wen) begin
        if (exp_fill.size() == 0) flag("fill_unexpected", $sformatf("fill of 0x%0h, none required", bus.ic_addr));
        else begin
          f = exp_fill.pop_front();
          check("fill_addr", bus.ic_addr, f.addr);
          check("fill_data", bus.ic_wdata, f.data);
        end
      end
      if (bus.ic_req_valid) n_lookup++;
    end
  end

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  hit_cnt,  exp_hit  % (1 << CNT_W));
    check({tag, "_miss_cnt"}, miss_cnt, exp_miss % (1 << CNT_W));
    check({tag, "_byp_cnt"},  byp_cnt,  exp_byp  % (1 << CNT_W));
  endtask

  task automatic fetch(input logic [29:0] wa, input bit err, input int rdly, input int mdly,
                       input bit spur, input int hold);
    logic [3:0]  idx;
    logic [31:0] d;
    bit uc, hit, fill;
    int lat, lk0, exp_lat, waited;
    idx  = wa[3:0];
    uc   = is_uc(wa);
    hit  = !uc && ref_v[idx] && (ref_tag[idx] == wa);
    fill = !uc && !hit && !err;
    d    = mem_word(wa);
    if (uc) exp_byp++; else if (hit) exp_hit++; else exp_miss++;
    if (!hit) exp_mem.push_back({wa, 2'b00});
    if (fill) begin
      exp_fill.push_back('{addr: wa, data: d});
      ref_v[idx] = 1'b1;
      ref_tag[idx] = wa;
    end
    exp_resp.push_back('{data: d, err: !hit && err});
    exp_lat = hit ? 2 : 4 + rdly + mdly + (fill ? 1 : 0);
    cfg_err = err; cfg_rdly = rdly; cfg_mdly = mdly; cfg_spur = spur;

    waited = 0;
    while (!bus.ifu_req_ready && waited < 50) begin @(negedge clock); waited++; end
    if (!bus.ifu_req_ready) begin flag("req_ready_timeout", "ready never rose within 50 cycles"); finish_sim(); return; end
    lk0 = n_lookup;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = wa;
    @(negedge clock);
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr = 30'($urandom);
    lat = 1;
    while (!bus.ifu_resp_valid && lat < 100) begin @(negedge clock); lat++; end
    if (!bus.ifu_resp_valid) begin flag("resp_timeout", "no response within 100 cycles"); finish_sim(); return; end
    check("latency", lat, exp_lat);
    check("ready_low_in_resp", bus.ifu_req_ready, 1'b0);
    repeat (hold) @(negedge clock);
    bus.ifu_resp_ready = 1'b1;
    @(negedge clock);
    bus.ifu_resp_ready = 1'b0;
    check("lookups", n_lookup - lk0, uc ? 0 : 1);
    check("back_to_idle", {bus.ifu_resp_valid, bus.ifu_req_ready}, 2'b01);
    check_counters("fetch");
  endtask

  initial begin : driver
    logic [29:0] wa;
    int waited;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0; bus.ifu_resp_ready = 1'b0;
    cfg_err = 0; cfg_spur = 0; cfg_late = 0; cfg_rdly = 0; cfg_mdly = 0;
    reset = 1'b1;
    #12;
    check("reset_ctrl", {bus.ifu_req_ready, bus.ifu_resp_valid, bus.ifu_resp_err, bus.ic_req_valid,
                         bus.ic_wen, bus.mem_req_valid, hit_cnt, miss_cnt, byp_cnt}, '0);
    check("reset_data", {bus.ifu_rdata | bus.ic_wdata | bus.mem_addr, bus.ic_addr}, '0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.ifu_req_ready, 1'b1);
    @(negedge clock);

    // Cold miss, refetch hit, conflict eviction.
    fetch(30'h2000_0004, 0, 0, 2, 0, 0);
    check("cold_miss_cnt", miss_cnt, 1);
    fetch(30'h2000_0004, 0, 0, 0, 0, 0);
    check("refetch_hit_cnt", hit_cnt, 1);
    fetch(30'h2000_0014, 0, 0, 0, 1, 0);
    fetch(30'h2000_0004, 0, 0, 0, 0, 0);
    check("conflict_miss_cnt", miss_cnt, 3);
    // Uncached window, twice: both go to memory.
    fetch(30'h2800_0000, 0, 0, 1, 0, 0);
    fetch(30'h2800_0000, 0, 1, 0, 0, 0);
    check("uncached_byp_cnt", byp_cnt, 2);
    // Memory backpressure with an error, then IFU backpressure on a hit.
    fetch(30'h2000_0008, 1, 4, 1, 0, 0);
    fetch(30'h2000_0004, 0, 0, 0, 0, 3);

    // Randomized traffic; small counters wrap along the way.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       wa = 30'h2800_0000 + 30'($urandom_range(0, 7));
        1:       wa = 30'($urandom_range(0, 63));
        default: wa = 30'h2000_0000 + 30'($urandom_range(0, 63));
      endcase
      fetch(wa, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end

    // Reset while waiting for memory; the late response must be ignored.
    cfg_late = 1; cfg_err = 0; cfg_spur = 0; cfg_rdly = 0;
    wa = 30'h2000_0440;
    exp_mem.push_back({wa, 2'b00});
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = wa;
    @(negedge clock);
    bus.ifu_req_valid = 1'b0;
    waited = 0;
    while (!bus.mem_req_valid && waited < 20) begin @(negedge clock); waited++; end
    if (!bus.mem_req_valid) begin flag("mem_req_timeout", "no memory request within 20 cycles"); finish_sim(); end
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("mid_miss_reset_ctrl", {bus.ifu_req_ready, bus.ifu_resp_valid, bus.ic_wen, bus.mem_req_valid,
                                  hit_cnt, miss_cnt, byp_cnt}, '0);
    exp_hit = 0; exp_miss = 0; exp_byp = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("post_reset_idle", {bus.ifu_req_ready, bus.ifu_resp_valid, bus.mem_req_valid}, 3'b100);
    check_counters("post_reset");
    cfg_late = 0;
    fetch(wa, 0, 0, 0, 0, 0);

    check("resp_queue_drained", exp_resp.size(), 0);
    check("fill_queue_drained", exp_fill.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    finish_sim();
  end
endmodule
